hazard_ctrl: RTL and testbench

- Producer side of the pipeline forwarding and stall interface.
- Tracks each in-flight instruction's destination register and remaining result latency (Tnew) through the E, M and W stages.
- Generates the forwarding selects consumed by the D-stage comparators, the E-stage ALU operand muxes and the M-stage store-data mux, plus the stall/flush controls for F, D and E.
- Sits beside the datapath; fed each cycle with register-usage info decoded in D.

---
 rtl/cpu_defs.sv | 17 +
 rtl/hazard_ctrl_fwd_sel.sv | 32 +++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared pipeline constants: forwarding-select encodings, the "source unused"
// Tuse marker and the result latency of each instruction class.
package cpu_defs;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        TNEW_NONE = 2'd0,
        TNEW_ALU  = 2'd1,
        TNEW_LOAD = 2'd2
    } tnew_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority encoder choosing the forwarding source for one operand:
// the M producer (if its result is ready), else the W producer, else the RF.
module fwd_sel
    import cpu_defs::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] m_a3_i,
    input  logic [T_W-1:0]    m_tnew_i,
    input  logic [REG_AW-1:0] w_a3_i,
    output logic [1:0]        sel_o
);

    logic m_hit;
    logic w_hit;

    assign m_hit = (src_i != '0) && (src_i == m_a3_i);
    assign w_hit = (src_i != '0) && (src_i == w_a3_i);

    always_comb begin
        sel_o = FWD_RF;
        // An M match still in flight blocks W: W would be a stale, older value.
        if (m_hit) begin
            sel_o = (m_tnew_i == '0) ? FWD_M : FWD_RF;
        end else if (w_hit) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W producer records and derives stall
// and forwarding selects. Optional counters enabled by HAZARD_STATS_EN.
module hazard_ctrl
    import cpu_defs::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic [T_W-1:0]    Tuse_rs_D,
    input  logic [T_W-1:0]    Tuse_rt_D,
    input  logic [REG_AW-1:0] A3_D,
    input  logic [T_W-1:0]    Tnew_D,
    output logic              stall,
    output logic [1:0]        MF_CMP1_Sel,
    output logic [1:0]        MF_CMP2_Sel,
    output logic [1:0]        MF_ALUA_Sel,
    output logic [1:0]        MF_ALUB_Sel,
    output logic              MF_DM_Sel
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    logic [REG_AW-1:0] e_rs_q, e_rs_d;
    logic [REG_AW-1:0] e_rt_q, e_rt_d;
    logic [REG_AW-1:0] e_a3_q, e_a3_d;
    logic [T_W-1:0]    e_tnew_q, e_tnew_d;
    logic [REG_AW-1:0] m_rt_q, m_rt_d;
    logic [REG_AW-1:0] m_a3_q, m_a3_d;
    logic [T_W-1:0]    m_tnew_q, m_tnew_d;
    logic [REG_AW-1:0] w_a3_q, w_a3_d;
    logic [1:0]        dm_sel;

    function automatic logic hit(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] a3);
        return (r != '0) && (r == a3);
    endfunction

    function automatic logic need_stall(input logic [REG_AW-1:0] r, input logic [T_W-1:0] tuse,
                                        input logic [REG_AW-1:0] ea3, input logic [T_W-1:0] etn,
                                        input logic [REG_AW-1:0] ma3, input logic [T_W-1:0] mtn);
        if (tuse == TUSE_NONE) return 1'b0;
        return (hit(r, ea3) && (etn > tuse)) || (hit(r, ma3) && (mtn > tuse));
    endfunction

    assign stall = need_stall(rs_D, Tuse_rs_D, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q)
                || need_stall(rt_D, Tuse_rt_D, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);

    always_comb begin
        e_rs_d   = rs_D;
        e_rt_d   = rt_D;
        e_a3_d   = A3_D;
        e_tnew_d = Tnew_D;
        // A stalled D instruction stays put, so E receives a bubble.
        if (stall) begin
            e_rs_d   = '0;
            e_rt_d   = '0;
            e_a3_d   = '0;
            e_tnew_d = '0;
        end
        m_rt_d   = e_rt_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q != '0) ? e_tnew_q - T_W'(1) : '0;
        w_a3_d   = m_a3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            m_rt_q   <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            w_a3_q   <= '0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            m_rt_q   <= m_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
        end
    end

    fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp1 (
        .src_i(rs_D), .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(MF_CMP1_Sel));
    fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_cmp2 (
        .src_i(rt_D), .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(MF_CMP2_Sel));
    fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_alua (
        .src_i(e_rs_q), .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(MF_ALUA_Sel));
    fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_alub (
        .src_i(e_rt_q), .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(MF_ALUB_Sel));

    // Store data in M can only be overtaken by the W producer.
    fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_dm (
        .src_i(m_rt_q), .m_a3_i('0), .m_tnew_i('0), .w_a3_i(w_a3_q), .sel_o(dm_sel));

    assign MF_DM_Sel = (dm_sel == FWD_W);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic        any_fwd;

    assign any_fwd = (MF_CMP1_Sel != FWD_RF) || (MF_CMP2_Sel != FWD_RF)
                  || (MF_ALUA_Sel != FWD_RF) || (MF_ALUB_Sel != FWD_RF) || MF_DM_Sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall)   stall_cnt_q <= stall_cnt_q + 32'd1;
            if (any_fwd) fwd_cnt_q   <= fwd_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random instruction
// streams, compared against an instruction-level pipeline model.
module tb_hazard_ctrl;
    import cpu_defs::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, A3_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
    logic       stall;
    logic [1:0] MF_CMP1_Sel, MF_CMP2_Sel, MF_ALUA_Sel, MF_ALUB_Sel;
    logic       MF_DM_Sel;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
    int unsigned exp_scnt, exp_fcnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_D(A3_D), .Tnew_D(Tnew_D),
        .stall(stall),
        .MF_CMP1_Sel(MF_CMP1_Sel), .MF_CMP2_Sel(MF_CMP2_Sel),
        .MF_ALUA_Sel(MF_ALUA_Sel), .MF_ALUB_Sel(MF_ALUB_Sel),
        .MF_DM_Sel(MF_DM_Sel)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    // Model: each in-flight instruction carries the absolute cycle its result is ready.
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        int         ready;
    } ins_t;

    ins_t stg[3];  // 0 = E, 1 = M, 2 = W
    int   now;
    int   errors = 0;
    int   checks = 0;

    logic       first_stall, first_dm;
    logic [1:0] first_cmp1, first_alua, first_alub;
    logic       obs_stall;
    logic [1:0] obs_cmp1, obs_alua, obs_alub;
    logic       obs_dm;

    function automatic bit hit(input logic [4:0] r, input logic [4:0] a3);
        return (r != 5'd0) && (r == a3);
    endfunction

    function automatic int remaining(input int k);
        int r;
        r = stg[k].ready - now;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (hit(src, stg[1].a3)) return (remaining(1) == 0) ? 2'b10 : 2'b00;
        if (hit(src, stg[2].a3)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit src_stalls(input logic [4:0] r, input logic [1:0] tuse);
        if (tuse == 2'd3) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (hit(r, stg[k].a3) && remaining(k) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, now);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) stg[k] = '{rs: 5'd0, rt: 5'd0, a3: 5'd0, ready: 0};
`ifdef HAZARD_STATS_EN
        exp_scnt = 0;
        exp_fcnt = 0;
`endif
    endtask

    task automatic check_cycle(output bit st, output bit any);
        logic [1:0] e1, e2, ea, eb;
        logic       ed, es;
        #1;
        es = src_stalls(rs_D, Tuse_rs_D) || src_stalls(rt_D, Tuse_rt_D);
        e1 = exp_fwd(rs_D);
        e2 = exp_fwd(rt_D);
        ea = exp_fwd(stg[0].rs);
        eb = exp_fwd(stg[0].rt);
        ed = hit(stg[1].rt, stg[2].a3);
        chk("stall", 32'(stall), 32'(es));
        chk("cmp1",  32'(MF_CMP1_Sel), 32'(e1));
        chk("cmp2",  32'(MF_CMP2_Sel), 32'(e2));
        chk("alua",  32'(MF_ALUA_Sel), 32'(ea));
        chk("alub",  32'(MF_ALUB_Sel), 32'(eb));
        chk("dm",    32'(MF_DM_Sel), 32'(ed));
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, exp_scnt);
        chk("fwd_cnt",   fwd_cnt, exp_fcnt);
`endif
        obs_stall = stall;
        obs_cmp1  = MF_CMP1_Sel;
        obs_alua  = MF_ALUA_Sel;
        obs_alub  = MF_ALUB_Sel;
        obs_dm    = MF_DM_Sel;
        st  = es;
        any = (e1 != 0) || (e2 != 0) || (ea != 0) || (eb != 0) || ed;
    endtask

    task automatic advance(input bit st, input bit any);
        @(posedge clk);
        stg[2] = stg[1];
        stg[1] = stg[0];
        if (st) stg[0] = '{rs: 5'd0, rt: 5'd0, a3: 5'd0, ready: 0};
        else    stg[0] = '{rs: rs_D, rt: rt_D, a3: A3_D, ready: now + 1 + int'(Tnew_D)};
`ifdef HAZARD_STATS_EN
        if (st)  exp_scnt++;
        if (any) exp_fcnt++;
`endif
        now++;
    endtask

    // Present one D instruction and hold it until it leaves D; count observed stalls.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                         input logic [1:0] tu_rt, input logic [4:0] a3, input logic [1:0] tn,
                         output int nst);
        bit st, any, done;
        nst  = 0;
        done = 0;
        for (int i = 0; i < 4 && !done; i++) begin
            @(negedge clk);
            rs_D = rs; rt_D = rt; Tuse_rs_D = tu_rs; Tuse_rt_D = tu_rt; A3_D = a3; Tnew_D = tn;
            check_cycle(st, any);
            if (i == 0) begin
                first_stall = obs_stall; first_cmp1 = obs_cmp1;
                first_alua = obs_alua; first_alub = obs_alub; first_dm = obs_dm;
            end
            if (obs_stall) nst++;
            advance(st, any);
            if (!st) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL stall_bound observed=stuck expected=release cycle=%0d", now);
        end
    endtask

    task automatic nop();
        int n;
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_NONE, n);
    endtask

    initial begin
        int  n;
        bit  st, any;
        reset = 1'b1;
        rs_D = '0; rt_D = '0; A3_D = '0; Tuse_rs_D = TUSE_NONE; Tuse_rt_D = TUSE_NONE; Tnew_D = '0;
        now = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_cycle(st, any);
        advance(st, any);

        // ALU back-to-back: M forwarding with no stall
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd1, TNEW_ALU, n);
        issue(5'd1, 5'd1, 2'd1, 2'd1, 5'd2, TNEW_ALU, n);
        chk("alu_b2b_stalls", n, 0);
        nop();
        chk("alu_b2b_alua", 32'(first_alua), 32'(2'b10));
        chk("alu_b2b_alub", 32'(first_alub), 32'(2'b10));

        // Load-use into ALU: one stall, then W forwarding
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd3, TNEW_LOAD, n);
        issue(5'd3, 5'd0, 2'd1, 2'd1, 5'd4, TNEW_ALU, n);
        chk("lw_use_stalls", n, 1);
        nop();
        chk("lw_use_alua", 32'(first_alua), 32'(2'b01));

        // Load into branch compare: two stalls
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, TNEW_LOAD, n);
        issue(5'd5, 5'd0, 2'd0, 2'd0, 5'd0, TNEW_NONE, n);
        chk("lw_beq_stalls", n, 2);
        nop();

        // Writes to $0 never create hazards
        repeat (3) issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_LOAD, n);
        issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, TNEW_NONE, n);
        chk("r0_stall", 32'(first_stall), 32'd0);
        chk("r0_cmp1", 32'(first_cmp1), 32'd0);

        // Younger M producer wins over older W producer
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd6, TNEW_LOAD, n);
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd6, TNEW_ALU, n);
        issue(5'd6, 5'd6, 2'd1, 2'd1, 5'd7, TNEW_ALU, n);
        chk("prio_stalls", n, 0);
        nop();
        chk("prio_alua", 32'(first_alua), 32'(2'b10));

        // M producer not ready: no fall-through to W; later DM forwarding from W
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd6, TNEW_LOAD, n);
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd6, TNEW_LOAD, n);
        issue(5'd0, 5'd6, TUSE_NONE, 2'd2, 5'd0, TNEW_NONE, n);
        nop();
        chk("m_busy_alub", 32'(first_alub), 32'(2'b00));
        nop();
        chk("dm_from_w", 32'(first_dm), 32'd1);

        // Reset during a load-use stall
        issue(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd3, TNEW_LOAD, n);
        @(negedge clk);
        rs_D = 5'd3; rt_D = 5'd0; Tuse_rs_D = 2'd1; Tuse_rt_D = 2'd1; A3_D = 5'd4; Tnew_D = TNEW_ALU;
        check_cycle(st, any);
        chk("pre_reset_stall", 32'(obs_stall), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        now++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_cycle(st, any);
        chk("post_reset_stall", 32'(obs_stall), 32'd0);
        chk("post_reset_alua", 32'(obs_alua), 32'd0);
        advance(st, any);

        // Random instruction stream over a small register set
        for (int i = 0; i < 300; i++) begin
            issue(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
